// File: rtl/accumulator_arbiter_if.sv
// Requester / accumulator / result-return bundle for accumulator_arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface accumulator_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            reqValidIn;
   logic [NUM_REQ-1:0]            reqLastIn;
   logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
   logic [NUM_REQ-1:0]            reqReadyOut;
   logic                          accumValidOut;
   logic                          accumLastOut;
   logic [DATA_WIDTH-1:0]         accumDataOut;
   logic                          accumValidIn;
   logic [DATA_WIDTH-1:0]         accumDataIn;
   logic [NUM_REQ-1:0]            resValidOut;
   logic [DATA_WIDTH-1:0]         resDataOut;
   logic [GW-1:0]                 grantOut;
   logic                          busyOut;

   modport slave (
      input  reqValidIn, reqLastIn, reqDataIn, accumValidIn, accumDataIn,
      output reqReadyOut, accumValidOut, accumLastOut, accumDataOut,
             resValidOut, resDataOut, grantOut, busyOut
   );

   modport master (
      output reqValidIn, reqLastIn, reqDataIn, accumValidIn, accumDataIn,
      input  reqReadyOut, accumValidOut, accumLastOut, accumDataOut,
             resValidOut, resDataOut, grantOut, busyOut
   );
endinterface

// File: rtl/accumulator_arbiter.sv
// Per-packet round-robin arbiter sharing one float accumulator among NUM_REQ requesters.
// Define ACCUM_ARB_TIMEOUT_EN to add a WAIT watchdog that returns qNaN after TIMEOUT_CYCLES.
module accumulator_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   accumulator_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_e;

   state_e                state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                  acc_vld_q, acc_vld_d;
   logic                  acc_last_q, acc_last_d;
   logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
   logic [NUM_REQ-1:0]    res_vld_q, res_vld_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

   logic [NUM_REQ-1:0]    grant_oh;
   logic [GW-1:0]         rr_next;
   logic                  pick_found;
   logic [GW-1:0]         pick_idx;
   logic [GW-1:0]         idx;
   logic                  timeout_hit;

   assign grant_oh = NUM_REQ'(1) << grant_q;
   assign rr_next  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // First requesting index at or after rr_ptr, wrapping upward.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!pick_found && bus.reqValidIn[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

`ifdef ACCUM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = '0;
      if (state_q == WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clkIn) begin
      if (rstIn) wait_cnt_q <= '0;
      else       wait_cnt_q <= wait_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      acc_vld_d  = 1'b0;
      acc_last_d = 1'b0;
      acc_data_d = '0;
      res_vld_d  = '0;
      res_data_d = res_data_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = STREAM;
            end
         end
         STREAM: begin
            // ready is one-hot(grant) here, so owner valid alone means a transfer
            if (bus.reqValidIn[grant_q]) begin
               acc_vld_d  = 1'b1;
               acc_last_d = bus.reqLastIn[grant_q];
               acc_data_d = bus.reqDataIn[grant_q*DATA_WIDTH +: DATA_WIDTH];
               if (bus.reqLastIn[grant_q]) state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.accumValidIn) begin
               res_vld_d  = grant_oh;
               res_data_d = bus.accumDataIn;
               rr_ptr_d   = rr_next;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               res_vld_d  = grant_oh;
               res_data_d = DATA_WIDTH'(32'h7FC0_0000);
               rr_ptr_d   = rr_next;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         acc_vld_q  <= 1'b0;
         acc_last_q <= 1'b0;
         acc_data_q <= '0;
         res_vld_q  <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         acc_vld_q  <= acc_vld_d;
         acc_last_q <= acc_last_d;
         acc_data_q <= acc_data_d;
         res_vld_q  <= res_vld_d;
         res_data_q <= res_data_d;
      end
   end

   assign bus.reqReadyOut   = (state_q == STREAM) ? grant_oh : '0;
   assign bus.accumValidOut = acc_vld_q;
   assign bus.accumLastOut  = acc_last_q;
   assign bus.accumDataOut  = acc_data_q;
   assign bus.resValidOut   = res_vld_q;
   assign bus.resDataOut    = res_data_q;
   assign bus.grantOut      = grant_q;
   assign bus.busyOut       = (state_q != IDLE);
endmodule

// File: tb/tb_accumulator_arbiter.sv
// Self-checking bench: packet queues per requester, a round-robin order model and an accumulator stand-in.
module tb_accumulator_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   accumulator_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   accumulator_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(1024)) dut (
      .clkIn (clk),
      .rstIn (rst),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          qd [N][$];
   bit          ql [N][$];
   int          psum [N][$];
   int          in_pkt [N];
   int          exp_own [$];
   logic [31:0] exp_sum [$];
   int          order_log [$];
   int          m_rr;
   bit          acc_pending, acc_silent, bubbles, junk;
   int          acc_wait, beat_cnt;
   logic [31:0] last_res;
   logic [3:0]  last_res_oh;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] int2f(int n);
      int e;
      logic [31:0] m;
      if (n == 0) return 32'd0;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      m = 32'(n) << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   function automatic logic [31:0] onehot(int r);
      return (r < 0) ? 32'd0 : (32'd1 << r);
   endfunction

   function automatic bit pending_any();
      bit p = acc_pending || (exp_own.size() > 0);
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic add_pkt(int r, int len, int base);
      int s = 0;
      for (int j = 0; j < len; j++) begin
         qd[r].push_back(base + j);
         ql[r].push_back(j == len - 1);
         s += base + j;
      end
      psum[r].push_back(s);
   endtask

   // Packet-level round robin over everything queued so far.
   task automatic plan();
      bit any, found;
      int i;
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (!found && psum[i].size() > 0) begin
               found = 1'b1;
               exp_own.push_back(i);
               exp_sum.push_back(int2f(psum[i].pop_front()));
               m_rr = (i + 1) % N;
            end
         end
         for (int k = 0; k < N; k++) if (psum[k].size() > 0) any = 1'b1;
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", 32'(bus.reqReadyOut), 0);
      chk("rst_acc_valid", 32'(bus.accumValidOut), 0);
      chk("rst_acc_last", 32'(bus.accumLastOut), 0);
      chk("rst_acc_data", bus.accumDataOut, 0);
      chk("rst_res_valid", 32'(bus.resValidOut), 0);
      chk("rst_res_data", bus.resDataOut, 0);
      chk("rst_grant", 32'(bus.grantOut), 0);
      chk("rst_busy", 32'(bus.busyOut), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.reqValidIn = '0;
      bus.reqLastIn = '0;
      bus.reqDataIn = '0;
      bus.accumValidIn = 1'b0;
      bus.accumDataIn = '0;
      tick();
      chk_reset_outputs();
      tick();
      chk_reset_outputs();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         qd[i].delete();
         ql[i].delete();
         psum[i].delete();
         in_pkt[i] = 0;
      end
      exp_own.delete();
      exp_sum.delete();
      order_log.delete();
      m_rr = 0;
      acc_pending = 1'b0;
      acc_silent = 1'b0;
      bubbles = 1'b0;
      junk = 1'b0;
      last_res = 32'd0;
      last_res_oh = '0;
      beat_cnt = 0;
   endtask

   // One cycle: drive requesters and accumulator, clock, then check the registered outputs.
   task automatic step();
      logic [N-1:0]    v, l, rdy;
      logic [N*DW-1:0] d;
      logic [31:0]     xd;
      bit              xl, fire;
      int              xi, own;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
         d[i*DW +: DW] = $urandom;
         l[i] = 1'($urandom);
         if (qd[i].size() > 0 && !(bubbles && in_pkt[i] > 0 && $urandom_range(3) == 0)) begin
            v[i] = 1'b1;
            d[i*DW +: DW] = int2f(qd[i][0]);
            l[i] = ql[i][0];
         end
      end
      bus.reqValidIn = v;
      bus.reqLastIn = l;
      bus.reqDataIn = d;
      fire = 1'b0;
      bus.accumValidIn = 1'b0;
      bus.accumDataIn = $urandom;
      if (acc_pending) begin
         if (!acc_silent) begin
            if (acc_wait == 0) begin
               fire = 1'b1;
               bus.accumValidIn = 1'b1;
               bus.accumDataIn = exp_sum[0];
            end else acc_wait--;
         end
      end else if (junk && $urandom_range(4) == 0) bus.accumValidIn = 1'b1;
      own = (exp_own.size() > 0) ? exp_own[0] : -1;
      rdy = bus.reqReadyOut;
      if (rdy != '0) begin
         chk("ready_owner", 32'(rdy), onehot(own));
         chk("grant", 32'(bus.grantOut), own);
      end
      xi = -1;
      xd = '0;
      xl = 1'b0;
      for (int i = 0; i < N; i++) if (v[i] && rdy[i]) begin
         xi = i;
         xd = d[i*DW +: DW];
         xl = l[i];
      end
      tick();
      if (xi >= 0) begin
         chk("acc_valid", 32'(bus.accumValidOut), 1);
         chk("acc_data", bus.accumDataOut, xd);
         chk("acc_last", 32'(bus.accumLastOut), 32'(xl));
         void'(qd[xi].pop_front());
         void'(ql[xi].pop_front());
         beat_cnt++;
         if (xl) begin
            in_pkt[xi] = 0;
            acc_pending = 1'b1;
            acc_wait = $urandom_range(3);
         end else in_pkt[xi]++;
      end else begin
         chk("acc_valid_idle", 32'(bus.accumValidOut), 0);
         chk("acc_data_idle", bus.accumDataOut, 0);
         chk("acc_last_idle", 32'(bus.accumLastOut), 0);
      end
      if (fire) begin
         chk("res_valid", 32'(bus.resValidOut), onehot(own));
         chk("res_data", bus.resDataOut, exp_sum[0]);
         chk("busy_after_res", 32'(bus.busyOut), 0);
         last_res = exp_sum[0];
         last_res_oh = bus.resValidOut;
         order_log.push_back(own);
         void'(exp_own.pop_front());
         void'(exp_sum.pop_front());
         acc_pending = 1'b0;
      end else begin
         chk("res_valid_quiet", 32'(bus.resValidOut), 0);
         chk("res_data_hold", bus.resDataOut, last_res);
      end
      if (acc_pending) chk("busy_wait", 32'(bus.busyOut), 1);
   endtask

   task automatic run(int budget);
      int c = 0;
      while (pending_any() && c < budget) begin
         step();
         c++;
      end
      chk("run_done", 32'(pending_any()), 0);
   endtask

   initial begin
      int c;
      bus.reqValidIn = '0;
      bus.reqLastIn = '0;
      bus.reqDataIn = '0;
      bus.accumValidIn = 1'b0;
      bus.accumDataIn = '0;
      do_reset();

      // 1.0 + 2.0 + 3.0 from req0
      add_pkt(0, 3, 1);
      plan();
      run(100);
      chk("p3_beats", beat_cnt, 3);
      chk("p3_sum", last_res, 32'h40C0_0000);
      chk("p3_owner", 32'(last_res_oh), 32'h1);

      // req0 and req2 together from rrPtr 0
      do_reset();
      add_pkt(0, 2, 1);
      add_pkt(2, 1, 4);
      plan();
      run(100);
      chk("two_n", order_log.size(), 2);
      if (order_log.size() == 2) begin
         chk("two_first", order_log[0], 0);
         chk("two_second", order_log[1], 2);
      end
      chk("two_sum", last_res, int2f(4));
      chk("two_owner", 32'(last_res_oh), 32'h4);

      // all four busy, 8 single-beat packets
      do_reset();
      for (int rep = 0; rep < 2; rep++)
         for (int r = 0; r < N; r++) add_pkt(r, 1, r + 1);
      plan();
      run(200);
      chk("rr_n", order_log.size(), 8);
      if (order_log.size() == 8)
         for (int i = 0; i < 8; i++) chk("rr_order", order_log[i], i % N);

      // single beat 5.0 on req1
      do_reset();
      add_pkt(1, 1, 5);
      plan();
      run(100);
      chk("single_beats", beat_cnt, 1);
      chk("single_sum", last_res, 32'h40A0_0000);
      chk("single_owner", 32'(last_res_oh), 32'h2);

      // reset mid-stream, stale result, rrPtr back to 0
      do_reset();
      add_pkt(1, 1, 7);
      plan();
      run(100);
      add_pkt(2, 4, 1);
      plan();
      beat_cnt = 0;
      c = 0;
      while (beat_cnt < 2 && c < 50) begin
         step();
         c++;
      end
      chk("mid_beats", beat_cnt, 2);
      chk("mid_busy", 32'(bus.busyOut), 1);
      do_reset();
      bus.accumValidIn = 1'b1;
      bus.accumDataIn = 32'h1234_5678;
      tick();
      bus.accumValidIn = 1'b0;
      chk("stale_res_valid", 32'(bus.resValidOut), 0);
      chk("stale_res_data", bus.resDataOut, 0);
      chk("stale_busy", 32'(bus.busyOut), 0);
      add_pkt(3, 1, 2);
      add_pkt(1, 1, 3);
      plan();
      run(100);
      chk("post_rst_n", order_log.size(), 2);
      if (order_log.size() == 2) chk("post_rst_first", order_log[0], 1);

      // randomized packets, bubbles and stray accumulator strobes
      do_reset();
      bubbles = 1'b1;
      junk = 1'b1;
      for (int round = 0; round < 12; round++) begin
         for (int r = 0; r < N; r++) begin
            int np = $urandom_range(2);
            for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(4, 1), $urandom_range(15, 1));
         end
         plan();
         run(600);
      end

`ifdef ACCUM_ARB_TIMEOUT_EN
      // accumulator never answers req3
      do_reset();
      add_pkt(3, 1, 9);
      plan();
      acc_silent = 1'b1;
      c = 0;
      while (!acc_pending && c < 50) begin
         step();
         c++;
      end
      chk("to_sent", 32'(acc_pending), 1);
      c = 0;
      bus.reqValidIn = '0;
      bus.accumValidIn = 1'b0;
      while (bus.resValidOut == '0 && c < 2000) begin
         tick();
         c++;
      end
      chk("to_cycles", c, 1024);
      chk("to_res_valid", 32'(bus.resValidOut), 32'h8);
      chk("to_res_data", bus.resDataOut, 32'h7FC0_0000);
      chk("to_busy", 32'(bus.busyOut), 0);
      acc_pending = 1'b0;
      acc_silent = 1'b0;
      exp_own.delete();
      exp_sum.delete();
      last_res = 32'h7FC0_0000;
      m_rr = 0;
      add_pkt(3, 1, 1);
      add_pkt(0, 1, 1);
      plan();
      order_log.delete();
      run(100);
      chk("to_rr_n", order_log.size(), 2);
      if (order_log.size() == 2) chk("to_rr_first", order_log[0], 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/accumulator_arbiter.md
ACCUMULATOR_ARBITER -- requirements
Module: accumulator_arbiter

Interface
REQ-001 Parameters SHALL be NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameters SHALL include DATA_WIDTH, default 32, the IEEE-754 single-precision sample width.
REQ-003 Parameters SHALL include TIMEOUT_CYCLES, default 1024, the result watchdog limit.
REQ-004 The module SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 clkIn  in  1  clock.
REQ-006 rstIn  in  1  synchronous active-high reset.
REQ-007 reqValidIn  in  NUM_REQ  per-requester sample valid.
REQ-008 reqLastIn  in  NUM_REQ  per-requester last-sample-of-packet flag.
REQ-009 reqDataIn  in  NUM_REQ*DATA_WIDTH  per-requester samples; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 reqReadyOut  out  NUM_REQ  per-requester sample accept.
REQ-011 accumValidOut, accumLastOut  out  1 each  sample valid and last flag to the accumulator.
REQ-012 accumDataOut  out  DATA_WIDTH  sample to the accumulator.
REQ-013 accumValidIn  in  1  accumulator result valid.
REQ-014 accumDataIn  in  DATA_WIDTH  accumulator result.
REQ-015 resValidOut  out  NUM_REQ  one-hot result-return pulse.
REQ-016 resDataOut  out  DATA_WIDTH  returned sum.
REQ-017 grantOut  out  $clog2(NUM_REQ)  current owner index.
REQ-018 busyOut  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, STREAM and WAIT.
REQ-020 In IDLE with any reqValidIn bit set, the block SHALL grant the first set bit at or after rrPtr, searching upward with wrap, latch grantOut, and enter STREAM on the next cycle.
REQ-021 In STREAM, reqReadyOut SHALL equal one-hot(grantOut); it SHALL be 0 in all other states.
REQ-022 A beat SHALL transfer when reqValidIn[g] and reqReadyOut[g] are both high.
REQ-023 Each transferred beat SHALL appear on accumValidOut/accumDataOut/accumLastOut one cycle later (registered); these outputs SHALL be 0 on cycles with no transfer.
REQ-024 A transferred beat with reqLastIn[g]=1 SHALL move the FSM to WAIT, and reqReadyOut SHALL drop in the following cycle.
REQ-025 A single-beat packet (last on the first beat) SHALL be legal and SHALL follow the same IDLE->STREAM->WAIT path.
REQ-026 In WAIT, accumValidIn=1 SHALL cause, on the next cycle: resValidOut[g]=1 for one cycle, resDataOut=accumDataIn registered, rrPtr=(g+1) mod NUM_REQ, and state=IDLE.
REQ-027 accumValidIn SHALL be ignored in IDLE and STREAM.
REQ-028 Grants SHALL be per-packet: no other requester is served until the owner's result returns.
REQ-029 Requests arriving during STREAM/WAIT SHALL be held off (ready=0) and SHALL NOT be lost.
REQ-030 resDataOut SHALL hold its last value between result pulses.

Reset
REQ-031 While rstIn is high, the block SHALL hold state=IDLE, rrPtr=0, grantOut=0, and all of reqReadyOut, accumValidOut, accumLastOut, accumDataOut, resValidOut, resDataOut and busyOut at 0.
REQ-032 Reset asserted mid-STREAM/WAIT SHALL abandon the packet; a late accumValidIn after reset SHALL be ignored.

Configuration
REQ-033 With ACCUM_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL exist, and reaching TIMEOUT_CYCLES without accumValidIn SHALL pulse resValidOut[g] with resDataOut=0x7FC00000 (qNaN), advance rrPtr and return to IDLE.
REQ-034 With ACCUM_ARB_TIMEOUT_EN undefined, no counter SHALL exist and WAIT SHALL persist until accumValidIn.

Verification
REQ-035 Req0 sends 1.0, 2.0, 3.0 (last on 3.0), accumulator model returns 0x40C00000 -> accumValidOut high 3 cycles, accumLastOut on the 3rd, resValidOut=0001, resDataOut=0x40C00000.
REQ-036 Req0 and req2 valid together at rrPtr=0 -> req0 packet served first, then grantOut=2; req2 receives its own sum.
REQ-037 All four requesters continuously valid for 8 single-beat packets -> grant order 0,1,2,3,0,1,2,3.
REQ-038 Req1 sends a single beat 5.0 with last -> one accumulator beat with last=1, resValidOut=0010 carrying the returned sum.
REQ-039 rstIn pulsed in STREAM after 2 beats, then a stale accumValidIn arrives -> no resValidOut pulse, state IDLE, rrPtr=0.
REQ-040 With ACCUM_ARB_TIMEOUT_EN defined, accumValidIn held low 1024 cycles in WAIT for req3 -> resValidOut=1000, resDataOut=0x7FC00000, busyOut=0.
